// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// SERIAL_TX_PARITY_EN adds the S_PARITY state encoding.
package serial_pkg;

  localparam int DEFAULT_DIVISOR    = 10416;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Bit-period timer: counts 0..DIVISOR-1 and pulses bit_done on the final cycle.
module baud_tick #(
  parameter int DIVISOR = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic bit_done_out
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last       = (r_count == LAST);
  assign bit_done_out = w_last;

  // Wrapping on the last cycle keeps bit periods back to back without an extra clear.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, LSB-first data, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DIVISOR    = DEFAULT_DIVISOR,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  busy_out
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [IW-1:0]         r_index, w_index_next;
  logic                  r_data_out, w_data_next;
  logic                  w_bit_done;
  logic                  w_tick_clear;
`ifdef SERIAL_TX_PARITY_EN
  logic                  r_parity, w_parity_next;
`endif

  assign ready_out    = (r_state == S_IDLE);
  assign busy_out     = ~ready_out;
  assign data_out     = r_data_out;
  assign w_tick_clear = (r_state == S_IDLE);

  baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (w_tick_clear),
    .bit_done_out(w_bit_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_index    <= '0;
      r_data_out <= STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_index    <= w_index_next;
      r_data_out <= w_data_next;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  // The line level is computed for the state being entered, so the
  // registered output lines up with the state register.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_index_next = r_index;
    w_data_next  = STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_state_next = S_START;
          w_shift_next = data_in;
          w_index_next = '0;
          w_data_next  = START_BIT;
`ifdef SERIAL_TX_PARITY_EN
          w_parity_next = ^data_in;
`endif
        end
      end
      S_START: begin
        w_data_next = START_BIT;
        if (w_bit_done) begin
          w_state_next = S_DATA;
          w_data_next  = r_shift[0];
        end
      end
      S_DATA: begin
        w_data_next = r_shift[0];
        if (w_bit_done) begin
          if (r_index == LAST_IDX) begin
            w_index_next = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_data_next  = r_parity;
`else
            w_state_next = S_STOP;
            w_data_next  = STOP_BIT;
`endif
          end else begin
            w_index_next = r_index + 1'b1;
            w_shift_next = r_shift >> 1;
            w_data_next  = w_shift_next[0];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        w_data_next = r_parity;
        if (w_bit_done) begin
          w_state_next = S_STOP;
          w_data_next  = STOP_BIT;
        end
      end
`endif
      S_STOP: begin
        w_data_next = STOP_BIT;
        if (w_bit_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_data_next  = STOP_BIT;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx at DIVISOR=4: table of frames plus random frames.
module tb_serial_tx;

  localparam int DIV = 4;
  localparam int DW  = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic          data_out;
  logic          busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx #(.DIVISOR(DIV), .DATA_WIDTH(DW)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  data;
    logic        hold;
    logic        chg;
    logic [9:0]  line_np;
    logic [10:0] line_p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame position i of byte d, from the framing rules.
  function automatic logic model_level(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return d[i-1];
    if (i == NB - 1) return 1'b1;
    return ^d;
  endfunction

  // Called at a negedge in S_IDLE; returns at the negedge of the first idle cycle after the frame.
  task automatic send_frame(input logic [7:0] d, input logic hold, input logic chg,
                            output logic [10:0] seen);
    int mismatches;
    seen = '0;
    mismatches = 0;
    chk("ready_before", 32'(ready_out), 32'd1);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk_in);
    if (!hold) valid_in = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < DIV; c++) begin
        if (data_out !== model_level(d, b) || ready_out !== 1'b0 || busy_out !== 1'b1)
          mismatches++;
        if (c == DIV / 2) seen[b] = data_out;
        if (chg) data_in = 8'($urandom);
        @(negedge clk_in);
      end
    end
    chk("frame_cycles_bad", 32'(mismatches), 32'd0);
    chk("ready_after_frame", 32'(ready_out), 32'd1);
    chk("line_idle_after", 32'(data_out), 32'd1);
    chk("busy_after_frame", 32'(busy_out), 32'd0);
  endtask

  vec_t vecs[6];
  logic [10:0] seen;
  logic [7:0] rd;
  int bad;

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b0, 10'b1010000010, 11'b10010000010};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 10'b1111111110, 11'b10111111110};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 10'b1000000000, 11'b10000000000};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 10'b1001111000, 11'b10001111000};
    vecs[4] = '{8'h07, 1'b0, 1'b0, 10'b1000001110, 11'b11000001110};
    vecs[5] = '{8'h03, 1'b0, 1'b0, 10'b1000000110, 11'b10000000110};

    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("reset_data_out", 32'(data_out), 32'd1);
    chk("reset_ready", 32'(ready_out), 32'd1);
    chk("reset_busy", 32'(busy_out), 32'd0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (data_out !== 1'b1 || ready_out !== 1'b1) bad++;
      @(negedge clk_in);
    end
    chk("idle_100_cycles", 32'(bad), 32'd0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].hold, vecs[v].chg, seen);
`ifdef SERIAL_TX_PARITY_EN
      chk($sformatf("line_%02h", vecs[v].data), 32'(seen), 32'(vecs[v].line_p));
`else
      chk($sformatf("line_%02h", vecs[v].data), 32'(seen[9:0]), 32'(vecs[v].line_np));
`endif
    end

    // Reset two cycles into data bit 3 of 0xA5.
    data_in  = 8'hA5;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < DIV * 4 + 2; i++) @(negedge clk_in);
    chk("pre_reset_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("midframe_rst_line", 32'(data_out), 32'd1);
    chk("midframe_rst_ready", 32'(ready_out), 32'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (data_out !== 1'b1 || ready_out !== 1'b1) bad++;
      @(negedge clk_in);
    end
    chk("no_bits_after_rst", 32'(bad), 32'd0);

    // Reset wins over a simultaneous acceptance.
    data_in  = 8'h00;
    valid_in = 1'b1;
    rst_in   = 1'b1;
    @(negedge clk_in);
    rst_in   = 1'b0;
    valid_in = 1'b0;
    chk("rst_priority_ready", 32'(ready_out), 32'd1);
    @(negedge clk_in);
    chk("rst_priority_line", 32'(data_out), 32'd1);

    for (int r = 0; r < 20; r++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), seen);
      valid_in = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
